// File: rtl/vga_timing_gen.sv
// vga_timing_gen: combined horizontal/vertical VGA timing generator.
// Counts pixel positions on pix_en, decodes sync/active/strobes from the
// next counter values so every output is registered alongside the counters.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          resync,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Window bounds are held one bit wider than the counters so a bound equal
  // to 2^HW (or 2^VW) is representable without truncation.
  localparam logic [HW:0] H_ACT_W  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_BEG_W = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END_W = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_ACT_W  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_BEG_W = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VS_END_W = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Reject configurations whose totals do not fit the counter widths.
  if (64'(H_TOTAL) > (64'd1 << HW)) begin : g_h_too_wide
    $error("vga_timing_gen: H_TOTAL exceeds 2**HW");
  end
  if (64'(V_TOTAL) > (64'd1 << VW)) begin : g_v_too_wide
    $error("vga_timing_gen: V_TOTAL exceeds 2**VW");
  end

  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          h_sync_win;
  logic          v_sync_win;
  logic          h_act;
  logic          v_act;
  logic          at_line0;
  logic          at_vblank;
  logic          at_frame0;

  // Next position for an enabled step: resync wins, else count and wrap at totals.
  always_comb begin
    h_nxt = hcount;
    v_nxt = vcount;
    if (resync) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (hcount == H_LAST) begin
      h_nxt = '0;
      if (vcount == V_LAST) begin
        v_nxt = '0;
      end else begin
        v_nxt = vcount + VW'(1);
      end
    end else begin
      h_nxt = hcount + HW'(1);
    end
  end

  // Decode of the next position, registered together with the counters so
  // outputs always describe the hcount/vcount they are presented with.
  always_comb begin
    h_sync_win = ({1'b0, h_nxt} >= HS_BEG_W) && ({1'b0, h_nxt} < HS_END_W);
    v_sync_win = ({1'b0, v_nxt} >= VS_BEG_W) && ({1'b0, v_nxt} < VS_END_W);
    h_act      = ({1'b0, h_nxt} < H_ACT_W);
    v_act      = ({1'b0, v_nxt} < V_ACT_W);
    at_line0   = (h_nxt == '0);
    at_frame0  = at_line0 && (v_nxt == '0);
    at_vblank  = at_line0 && ({1'b0, v_nxt} == V_ACT_W);
  end

  // Counter and output registers; strobes are cleared on non-enabled clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount       <= '0;
      vcount       <= '0;
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
      active       <= 1'b1;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else if (pix_en) begin
      hcount       <= h_nxt;
      vcount       <= v_nxt;
      hsync        <= h_sync_win ? H_POL : ~H_POL;
      vsync        <= v_sync_win ? V_POL : ~V_POL;
      active       <= h_act && v_act;
      line_start   <= at_line0;
      frame_start  <= at_frame0;
      vblank_start <= at_vblank;
    end else begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized and directed checks of vga_timing_gen against
// a linear-position reference model (position p = v*H_TOTAL + h, mod frame).
module tb_vga_timing_gen;

  // Small configuration
  localparam int SHA = 4, SHF = 1, SHS = 2, SHB = 1;
  localparam int SVA = 3, SVF = 1, SVS = 1, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFR = SHT * SVT;
  // Default 640x480 configuration
  localparam int DHA = 640, DHF = 16, DHS = 96, DHB = 48;
  localparam int DVA = 480, DVF = 10, DVS = 2,  DVB = 33;
  localparam int DHT = DHA + DHF + DHS + DHB;
  localparam int DVT = DVA + DVF + DVS + DVB;
  localparam int DFR = DHT * DVT;

  logic clk;
  logic rst, s_en, s_res;
  logic d_rst, d_en, d_res;

  logic [2:0] s_hc;
  logic [2:0] s_vc;
  logic s_hs, s_vs, s_act, s_ls, s_fs, s_vb;
  logic [9:0] d_hc;
  logic [9:0] d_vc;
  logic d_hs, d_vs, d_act, d_ls, d_fs, d_vb;

  logic [11:0] obs_s;
  logic [25:0] obs_d;
  assign obs_s = {s_hc, s_vc, s_hs, s_vs, s_act, s_ls, s_fs, s_vb};
  assign obs_d = {d_hc, d_vc, d_hs, d_vs, d_act, d_ls, d_fs, d_vb};

  int checks = 0;
  int passed = 0;
  int ps = 0, pd = 0;
  bit sts = 1'b0, std = 1'b0;

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .H_POL(1'b0), .V_POL(1'b1), .HW(3), .VW(3)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(s_en), .resync(s_res),
    .hcount(s_hc), .vcount(s_vc), .hsync(s_hs), .vsync(s_vs),
    .active(s_act), .line_start(s_ls), .frame_start(s_fs),
    .vblank_start(s_vb)
  );

  vga_timing_gen u_def (
    .clk(clk), .rst(d_rst), .pix_en(d_en), .resync(d_res),
    .hcount(d_hc), .vcount(d_vc), .hsync(d_hs), .vsync(d_vs),
    .active(d_act), .line_start(d_ls), .frame_start(d_fs),
    .vblank_start(d_vb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs of the small config at linear position p; st = enabled step happened.
  function automatic logic [11:0] exp_s(int p, bit st);
    int h, v;
    logic hs, vs, act, ls, fs, vb;
    h   = p % SHT;
    v   = p / SHT;
    hs  = (h >= SHA + SHF && h < SHA + SHF + SHS) ? 1'b0 : 1'b1;
    vs  = (v >= SVA + SVF && v < SVA + SVF + SVS) ? 1'b1 : 1'b0;
    act = (h < SHA) && (v < SVA);
    ls  = st && (h == 0);
    fs  = ls && (v == 0);
    vb  = ls && (v == SVA);
    return {3'(h), 3'(v), hs, vs, act, ls, fs, vb};
  endfunction

  // Expected outputs of the default config (both polarities active-low).
  function automatic logic [25:0] exp_d(int p, bit st);
    int h, v;
    logic hs, vs, act, ls, fs, vb;
    h   = p % DHT;
    v   = p / DHT;
    hs  = (h >= DHA + DHF && h < DHA + DHF + DHS) ? 1'b0 : 1'b1;
    vs  = (v >= DVA + DVF && v < DVA + DVF + DVS) ? 1'b0 : 1'b1;
    act = (h < DHA) && (v < DVA);
    ls  = st && (h == 0);
    fs  = ls && (v == 0);
    vb  = ls && (v == DVA);
    return {10'(h), 10'(v), hs, vs, act, ls, fs, vb};
  endfunction

  // One clock: advance both reference models from the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ps = 0; sts = 1'b0;
    end else if (s_en) begin
      ps = s_res ? 0 : (ps + 1) % SFR; sts = 1'b1;
    end else begin
      sts = 1'b0;
    end
    if (d_rst) begin
      pd = 0; std = 1'b0;
    end else if (d_en) begin
      pd = d_res ? 0 : (pd + 1) % DFR; std = 1'b1;
    end else begin
      std = 1'b0;
    end
    #1;
  endtask

  task automatic reset_small();
    rst = 1'b1; s_en = 1'b0; s_res = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; d_rst = 1'b1;
    s_en = 1'b1; s_res = 1'b1; d_en = 1'b1; d_res = 1'b0;
    tick();
    rst = 1'b0; d_rst = 1'b0; s_en = 1'b0; s_res = 1'b0; d_en = 1'b0;
    checks++;
    if (obs_d !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 3'b000})
      $display("FAIL reset_default got %h want %h", obs_d, {10'd0, 10'd0, 6'b111000});
    else passed++;
    checks++;
    if (obs_s !== exp_s(0, 1'b0))
      $display("FAIL reset_small got %h want %h", obs_s, exp_s(0, 1'b0));
    else passed++;
    tick();
    checks++;
    if (obs_d !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 3'b000})
      $display("FAIL idle_default got %h want %h", obs_d, {10'd0, 10'd0, 6'b111000});
    else passed++;
    checks++;
    if (obs_s !== exp_s(ps, sts))
      $display("FAIL idle_small got %h want %h", obs_s, exp_s(ps, sts));
    else passed++;
  endtask

  task automatic test_continuous();
    int n_ls, n_fs, n_vb, bad;
    n_ls = 0; n_fs = 0; n_vb = 0; bad = 0;
    reset_small();
    s_en = 1'b1;
    for (int i = 0; i < 2 * SFR; i++) begin
      tick();
      checks++;
      if (obs_s !== exp_s(ps, sts)) begin
        bad++;
        if (bad <= 5) $display("FAIL cont_step%0d got %h want %h", i, obs_s, exp_s(ps, sts));
      end else passed++;
      n_ls += int'(s_ls); n_fs += int'(s_fs); n_vb += int'(s_vb);
    end
    checks++;
    if (n_ls !== 2 * SVT) $display("FAIL cont_line_starts got %0d want %0d", n_ls, 2 * SVT);
    else passed++;
    checks++;
    if (n_fs !== 2) $display("FAIL cont_frame_starts got %0d want 2", n_fs);
    else passed++;
    checks++;
    if (n_vb !== 2) $display("FAIL cont_vblank_starts got %0d want 2", n_vb);
    else passed++;
  endtask

  task automatic test_toggle();
    int bad, n_fs;
    bad = 0; n_fs = 0;
    reset_small();
    for (int i = 0; i < 4 * SFR; i++) begin
      s_en = (i % 2 == 0);
      tick();
      checks++;
      if (obs_s !== exp_s(ps, sts)) begin
        bad++;
        if (bad <= 5) $display("FAIL toggle_step%0d got %h want %h", i, obs_s, exp_s(ps, sts));
      end else passed++;
      n_fs += int'(s_fs);
    end
    s_en = 1'b0;
    checks++;
    if ({s_hc, s_vc} !== 6'd0) $display("FAIL toggle_end_pos got %h want 00", {s_hc, s_vc});
    else passed++;
    checks++;
    if (n_fs !== 2) $display("FAIL toggle_frame_starts got %0d want 2", n_fs);
    else passed++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    reset_small();
    for (int i = 0; i < 600; i++) begin
      s_en  = 1'($urandom_range(0, 1));
      s_res = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (obs_s !== exp_s(ps, sts)) begin
        bad++;
        if (bad <= 5) $display("FAIL random_step%0d got %h want %h", i, obs_s, exp_s(ps, sts));
      end else passed++;
    end
    s_en = 1'b0; s_res = 1'b0;
  endtask

  task automatic test_resync();
    reset_small();
    s_en = 1'b1;
    repeat (2 * SHT + 5) tick();
    checks++;
    if ({s_hc, s_vc} !== {3'd5, 3'd2}) $display("FAIL resync_pre_pos got %h want %h", {s_hc, s_vc}, {3'd5, 3'd2});
    else passed++;
    s_en = 1'b0; s_res = 1'b1;
    tick();
    checks++;
    if (obs_s !== exp_s(2 * SHT + 5, 1'b0))
      $display("FAIL resync_disabled got %h want %h", obs_s, exp_s(2 * SHT + 5, 1'b0));
    else passed++;
    s_en = 1'b1;
    tick();
    s_en = 1'b0; s_res = 1'b0;
    checks++;
    if ({s_hc, s_vc, s_ls, s_fs, s_vb} !== {3'd0, 3'd0, 3'b110})
      $display("FAIL resync_enabled got %h want %h", {s_hc, s_vc, s_ls, s_fs, s_vb}, {3'd0, 3'd0, 3'b110});
    else passed++;
    checks++;
    if (obs_s !== exp_s(ps, sts)) $display("FAIL resync_model got %h want %h", obs_s, exp_s(ps, sts));
    else passed++;
  endtask

  task automatic test_reset_mid();
    reset_small();
    s_en = 1'b1;
    repeat (4 * SHT + 6) tick();
    checks++;
    if ({s_hc, s_vc} !== {3'd6, 3'd4}) $display("FAIL rstmid_pre_pos got %h want %h", {s_hc, s_vc}, {3'd6, 3'd4});
    else passed++;
    rst = 1'b1; s_res = 1'b1;
    tick();
    checks++;
    if (obs_s !== exp_s(0, 1'b0)) $display("FAIL rstmid_reset got %h want %h", obs_s, exp_s(0, 1'b0));
    else passed++;
    rst = 1'b0; s_res = 1'b0;
    tick();
    checks++;
    if ({s_hc, s_vc, s_ls} !== {3'd1, 3'd0, 1'b0}) $display("FAIL rstmid_resume got %h want %h", {s_hc, s_vc, s_ls}, 7'h10);
    else passed++;
    s_en = 1'b0;
  endtask

  task automatic test_default();
    int bad, n_low, first_low;
    bad = 0; n_low = 0; first_low = -1;
    d_rst = 1'b1; d_en = 1'b0; d_res = 1'b0;
    tick();
    d_rst = 1'b0; d_en = 1'b1;
    for (int i = 0; i < 3 * DHT; i++) begin
      tick();
      checks++;
      if (obs_d !== exp_d(pd, std)) begin
        bad++;
        if (bad <= 5) $display("FAIL default_step%0d got %h want %h", i, obs_d, exp_d(pd, std));
      end else passed++;
      if (d_hs === 1'b0) begin
        n_low++;
        if (first_low < 0) first_low = int'(d_hc);
      end
    end
    d_en = 1'b0;
    checks++;
    if (n_low !== 3 * DHS) $display("FAIL default_hsync_low got %0d want %0d", n_low, 3 * DHS);
    else passed++;
    checks++;
    if (first_low !== DHA + DHF) $display("FAIL default_hsync_first got %0d want %0d", first_low, DHA + DHF);
    else passed++;
    checks++;
    if ({d_hc, d_vc} !== {10'd0, 10'd3}) $display("FAIL default_end_pos got %h want %h", {d_hc, d_vc}, {10'd0, 10'd3});
    else passed++;
  endtask

  initial begin
    rst = 1'b0; s_en = 1'b0; s_res = 1'b0;
    d_rst = 1'b0; d_en = 1'b0; d_res = 1'b0;
    #2;
    test_reset();
    test_continuous();
    test_toggle();
    test_random();
    test_resync();
    test_reset_mid();
    test_default();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
